irq_pending_ctrl: RTL and testbench

- Upstream stage for the 8-to-3 MSB-priority encoder.
- Captures raw request lines into a sticky pending register and applies a per-source enable mask.
- Picks the highest-index eligible source and presents its index with a valid/ready handshake.
- Clears the serviced pending bit when the consumer accepts.

---
 rtl/irq_pending_ctrl.sv | 118 +++++++++++
 tb/tb_irq_pending_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// Sticky interrupt pending register with enable mask, MSB-priority grant and valid/ready handoff.
// Optional IRQ_EDGE_DET_EN: rising-edge event detection plus sticky per-source lost-event flags.
module irq_pending_ctrl #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req_in,
  input  logic [N_SRC-1:0] mask,
  output logic             irq_valid,
  input  logic             irq_ready,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] lost,
  input  logic [N_SRC-1:0] lost_clr
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr_vec;
  logic [ID_W-1:0]  top_idx;
  logic             accept;

`ifdef IRQ_EDGE_DET_EN
  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] lost_q, lost_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= '0;
      lost_q <= '0;
    end else begin
      req_q  <= req_in;
      lost_q <= lost_d;
    end
  end

  assign evt = req_in & ~req_q;

  // An event on an already-pending source that is not being serviced overruns it.
  always_comb begin
    lost_d = (lost_q & ~lost_clr) | (evt & pending_q & ~clr_vec);
  end

  assign lost = lost_q;
`else
  logic unused_lost_clr;

  assign evt             = req_in;
  assign lost            = '0;
  assign unused_lost_clr = ^lost_clr;
`endif

  // State, grant index and pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_id_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
    end
  end

  assign eligible = pending_q & mask;

  // Highest set index of eligible; ascending scan so the last hit wins.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (eligible[i]) top_idx = ID_W'(i);
    end
  end

  // Next-state and grant capture.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_d  = PRESENT;
          irq_id_d = top_idx;
        end
      end
      PRESENT: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    irq_valid = 1'b0;
    accept    = 1'b0;
    if (state_q == PRESENT) begin
      irq_valid = 1'b1;
      accept    = irq_ready;
    end
  end

  assign clr_vec   = accept ? (N_SRC'(1) << irq_id_q) : '0;
  // A new event beats the clear of the serviced bit.
  assign pending_d = evt | (pending_q & ~clr_vec);

  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed vector table, corner sequences and
// randomized traffic checked against a rule-level reference model.
module tb_irq_pending_ctrl;

`ifdef IRQ_EDGE_DET_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in, mask, lost_clr;
  logic       irq_ready;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending, lost;

  int errors = 0;
  int checks = 0;

  irq_pending_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
    .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_id(irq_id),
    .pending(pending), .lost(lost), .lost_clr(lost_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_pend[8];
  bit m_lost[8];
  bit m_prev[8];
  bit m_valid;
  int m_id;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic [7:0] exp_pend;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack8(input bit b[8]);
    int v = 0;
    for (int i = 0; i < 8; i++) if (b[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 0; m_lost[i] = 0; m_prev[i] = 0;
    end
    m_valid = 0;
    m_id    = 0;
  endtask

  // One clock edge worth of the behavioural rules, using inputs as sampled at the edge.
  task automatic model_edge();
    bit acc;
    int cleared;
    int pick;
    bit e;
    bit np[8];
    bit nl[8];
    acc     = m_valid && irq_ready;
    cleared = acc ? m_id : -1;
    pick    = -1;
    for (int i = 0; i < 8; i++) if (m_pend[i] && mask[i]) pick = i;
    for (int i = 0; i < 8; i++) begin
      e     = EDGE ? (req_in[i] && !m_prev[i]) : req_in[i];
      np[i] = e ? 1'b1 : ((i == cleared) ? 1'b0 : m_pend[i]);
      if (!EDGE)                                 nl[i] = 1'b0;
      else if (e && m_pend[i] && i != cleared)   nl[i] = 1'b1;
      else if (lost_clr[i])                      nl[i] = 1'b0;
      else                                       nl[i] = m_lost[i];
    end
    if (!m_valid) begin
      if (pick >= 0) begin
        m_valid = 1;
        m_id    = pick;
      end
    end else if (acc) begin
      m_valid = 0;
    end
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = np[i];
      m_lost[i] = nl[i];
      m_prev[i] = req_in[i];
    end
  endtask

  // Advance one clock, update the model, then compare all outputs away from the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_valid",   int'(irq_valid), int'(m_valid));
    chk("model_id",      int'(irq_id),    m_id);
    chk("model_pending", int'(pending),   pack8(m_pend));
    chk("model_lost",    int'(lost),      pack8(m_lost));
  endtask

  task automatic do_reset();
    req_in = 8'h00; mask = 8'hFF; irq_ready = 1'b0; lost_clr = 8'h00;
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] m, input logic rd,
                     input logic ev, input logic [2:0] eid, input logic [7:0] ep);
    vec_t v;
    v.req = r; v.mask = m; v.ready = rd; v.exp_valid = ev; v.exp_id = eid; v.exp_pend = ep;
    tbl.push_back(v);
  endtask

  int grants;

  initial begin
    req_in = 8'h00; mask = 8'hFF; irq_ready = 1'b0; lost_clr = 8'h00;
    rst = 1'b1;
    model_reset();
    #3;
    chk("reset_valid",   int'(irq_valid), 0);
    chk("reset_pending", int'(pending),   0);
    chk("reset_id",      int'(irq_id),    0);
    #9;
    rst = 1'b0;

    // Idle cycles, two-source burst, masked hold, re-pend on accept
    for (int k = 0; k < 5; k++) add(8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00);
    add(8'h24, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h24);
    add(8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h24);
    add(8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h04);
    add(8'h00, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h04);
    add(8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00);
    add(8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00);
    add(8'h81, 8'h01, 1'b0, 1'b0, 3'd2, 8'h81);
    add(8'h00, 8'h01, 1'b0, 1'b1, 3'd0, 8'h81);
    add(8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h81);
    add(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h80);
    add(8'h00, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h80);
    add(8'h00, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h00);
    add(8'h08, 8'hFF, 1'b0, 1'b0, 3'd7, 8'h08);
    add(8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08);
    add(8'h08, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h08);
    add(8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08);
    add(8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00);

    foreach (tbl[k]) begin
      req_in = tbl[k].req; mask = tbl[k].mask; irq_ready = tbl[k].ready;
      step();
      chk($sformatf("vec%0d_valid", k), int'(irq_valid), int'(tbl[k].exp_valid));
      chk($sformatf("vec%0d_id", k),    int'(irq_id),    int'(tbl[k].exp_id));
      chk($sformatf("vec%0d_pend", k),  int'(pending),   int'(tbl[k].exp_pend));
      chk($sformatf("vec%0d_lost", k),  int'(lost),      0);
    end

`ifdef IRQ_EDGE_DET_EN
    // Held request pends once; a fresh edge while still pending flags lost.
    do_reset();
    req_in = 8'h10;
    for (int k = 0; k < 10; k++) step();
    chk("hold_pending", int'(pending), 8'h10);
    chk("hold_lost",    int'(lost),    0);
    chk("hold_id",      int'(irq_id),  4);
    req_in = 8'h00; step();
    req_in = 8'h10; step();
    chk("retrig_lost", int'(lost), 8'h10);
    lost_clr = 8'h10; step();
    lost_clr = 8'h00;
    chk("lostclr_lost", int'(lost), 0);
`else
    // Level mode: a held request with ready high is granted every other cycle.
    do_reset();
    req_in = 8'h10; irq_ready = 1'b1;
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (irq_valid) grants++;
    end
    chk("level_grant_count", grants, 5);
`endif

    // Asynchronous reset in the middle of a presented grant.
    do_reset();
    req_in = 8'h40;
    step();
    req_in = 8'h00;
    step();
    chk("pre_rst_valid", int'(irq_valid), 1);
    chk("pre_rst_id",    int'(irq_id),    6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid",   int'(irq_valid), 0);
    chk("async_rst_pending", int'(pending),   0);
    chk("async_rst_lost",    int'(lost),      0);
    model_reset();
    rst = 1'b0;
    irq_ready = 1'b1;
    step();
    chk("post_rst_valid", int'(irq_valid), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mask      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      irq_ready = 1'($urandom);
      lost_clr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
